// File: rtl/ctrl_pkg.sv
// Shared control-bundle layout, opcode constants and memory-size encodings
// for the pipelined MIPS control unit.
package ctrl_pkg;

  localparam int CTRL_W = 21;

  localparam int LINK_BIT      = 20;
  localparam int ALUOP_LSB     = 14;
  localparam int ALUSRC_BIT    = 13;
  localparam int BRANCH_BIT    = 12;
  localparam int JUMP_BIT      = 11;
  localparam int MEMREAD_BIT   = 10;
  localparam int MEMWRITE_BIT  = 9;
  localparam int MEMSIZE_LSB   = 7;
  localparam int MEMTOREG_BIT  = 6;
  localparam int REGWRITE_BIT  = 5;
  localparam int DEST_LSB      = 0;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  typedef enum logic [1:0] {
    MEM_WORD = 2'd0,
    MEM_HALF = 2'd1,
    MEM_BYTE = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic       link;
    logic [5:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    mem_size_e  mem_size;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] dest_reg;
  } ctrl_t;

  // Loads and stores share the low opcode bits: x11 word, x01 half, x00 byte.
  function automatic mem_size_e mem_size_of(input logic [5:0] op);
    case (op[1:0])
      2'b11:   return MEM_WORD;
      2'b01:   return MEM_HALF;
      default: return MEM_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational ID-stage decoder: instruction word to control bundle,
// illegal-opcode flag and register-source information for hazard checks.
module control_decoder
  import ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31
) (
  input  logic [31:0]      instr_i,
  output ctrl_t            ctrl_o,
  output logic             illegal_o,
  output logic             uses_rt_o,
  output logic [REG_W-1:0] rs_o,
  output logic [REG_W-1:0] rt_o
);

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rd;
  logic             unused_bits;

  assign op          = instr_i[31 -: OP_W];
  assign rs_o        = instr_i[25 -: REG_W];
  assign rt_o        = instr_i[20 -: REG_W];
  assign rd          = instr_i[15 -: REG_W];
  assign unused_bits = ^instr_i[10:0];

  always_comb begin
    ctrl_o        = '0;
    illegal_o     = 1'b0;
    uses_rt_o     = 1'b0;
    ctrl_o.alu_op = op;
    case (op)
      OP_RTYPE: begin
        ctrl_o.dest_reg   = rd;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        uses_rt_o         = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl_o.dest_reg   = rt_o;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      OP_LW, OP_LH, OP_LB: begin
        ctrl_o.dest_reg  = rt_o;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.mem_size  = mem_size_of(op);
      end
      OP_SW, OP_SH, OP_SB: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.mem_size  = mem_size_of(op);
        uses_rt_o        = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_o.branch = 1'b1;
        uses_rt_o     = 1'b1;
      end
      OP_BLEZ, OP_BGTZ, OP_REGIMM: ctrl_o.branch = 1'b1;
      OP_J: ctrl_o.jump = 1'b1;
      OP_JAL: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.link      = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.dest_reg  = 5'(LINK_REG);
      end
      default: begin
        ctrl_o    = '0;
        illegal_o = 1'b1;
      end
    endcase
    // $zero is hardwired, so a write to it is never architecturally visible.
    if (ctrl_o.dest_reg == '0) ctrl_o.reg_write = 1'b0;
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: ID/EX, EX/MEM and MEM/WB control registers with
// load-use stall insertion, branch flush and saturating event counters.
module pipe_control_unit
  import ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [31:0]       Instruction,
  input  logic              InstrValid,
  input  logic              Flush,
  output logic [CTRL_W-1:0] ExCtrl,
  output logic [CTRL_W-1:0] MemCtrl,
  output logic [CTRL_W-1:0] WbCtrl,
  output logic              Stall,
  output logic              PCWrite,
  output logic              IfIdWrite,
  output logic              IfIdFlush,
  output logic              IllegalOp,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  ctrl_t            dec;
  logic             dec_illegal;
  logic             uses_rt;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;

  ctrl_t            ex_q, ex_d, mem_q, wb_q;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  control_decoder #(
    .OP_W    (OP_W),
    .REG_W   (REG_W),
    .LINK_REG(LINK_REG)
  ) u_decoder (
    .instr_i  (Instruction),
    .ctrl_o   (dec),
    .illegal_o(dec_illegal),
    .uses_rt_o(uses_rt),
    .rs_o     (rs),
    .rt_o     (rt)
  );

  // Load in EX whose destination is read by the instruction now in ID.
  always_comb begin
    Stall = InstrValid & ex_q.mem_read & (ex_q.dest_reg != '0) &
            ((ex_q.dest_reg == rs) | (uses_rt & (ex_q.dest_reg == rt)));
  end

  assign PCWrite   = ~Stall | Flush;
  assign IfIdWrite = ~Stall | Flush;
  assign IfIdFlush = Flush;

  always_comb begin
    ex_d        = dec;
    illegal_d   = illegal_q | (InstrValid & dec_illegal);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Flush || Stall || !InstrValid) ex_d = '0;
    if (Stall && !Flush && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (Flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      illegal_q   <= illegal_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ExCtrl     = ex_q;
  assign MemCtrl    = mem_q;
  assign WbCtrl     = wb_q;
  assign IllegalOp  = illegal_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: directed scenarios plus randomized traffic
// checked against an instruction-level reference model.
module tb_pipe_control_unit;

  localparam int CW    = 21;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [31:0]     Instruction;
  logic            InstrValid;
  logic            Flush;
  logic [CW-1:0]   ExCtrl, MemCtrl, WbCtrl;
  logic            Stall, PCWrite, IfIdWrite, IfIdFlush, IllegalOp;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [CW-1:0] m_ex, m_mem, m_wb;
  int            m_sc, m_fc;
  logic          m_ill;

  pipe_control_unit #(.CNT_W(CNT_W)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Instruction(Instruction),
    .InstrValid (InstrValid),
    .Flush      (Flush),
    .ExCtrl     (ExCtrl),
    .MemCtrl    (MemCtrl),
    .WbCtrl     (WbCtrl),
    .Stall      (Stall),
    .PCWrite    (PCWrite),
    .IfIdWrite  (IfIdWrite),
    .IfIdFlush  (IfIdFlush),
    .IllegalOp  (IllegalOp),
    .StallCount (StallCount),
    .FlushCount (FlushCount)
  );

  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
  endfunction

  function automatic logic ref_illegal(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    return !(op inside {6'o00, 6'o01, 6'o02, 6'o03, 6'o04, 6'o05, 6'o06, 6'o07,
                        6'o10, 6'o14, 6'o15, 6'o16, 6'o40, 6'o41, 6'o43,
                        6'o50, 6'o51, 6'o53});
  endfunction

  function automatic logic ref_uses_rt(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    return op inside {6'b000000, 6'b101011, 6'b101001, 6'b101000, 6'b000100, 6'b000101};
  endfunction

  function automatic logic [CW-1:0] ref_decode(input logic [31:0] ins);
    logic [5:0] op;
    logic [4:0] rt, rd, dst;
    logic       lk, src, br, jp, mr, mw, m2r, rw;
    logic [1:0] sz;
    op = ins[31:26]; rt = ins[20:16]; rd = ins[15:11];
    {lk, src, br, jp, mr, mw, m2r, rw} = '0;
    sz = 2'd0; dst = 5'd0;
    if (ref_illegal(ins)) return '0;
    case (op)
      6'b000000: begin dst = rd; rw = 1; m2r = 1; end
      6'b001000, 6'b001100, 6'b001101, 6'b001110: begin dst = rt; src = 1; rw = 1; m2r = 1; end
      6'b100011, 6'b100001, 6'b100000: begin
        dst = rt; src = 1; mr = 1; rw = 1;
        sz = (op == 6'b100011) ? 2'd0 : (op == 6'b100001) ? 2'd1 : 2'd2;
      end
      6'b101011, 6'b101001, 6'b101000: begin
        src = 1; mw = 1;
        sz = (op == 6'b101011) ? 2'd0 : (op == 6'b101001) ? 2'd1 : 2'd2;
      end
      6'b000010: jp = 1;
      6'b000011: begin jp = 1; lk = 1; rw = 1; dst = 5'd31; end
      default: br = 1;
    endcase
    if (dst == 5'd0) rw = 0;
    return {lk, op, src, br, jp, mr, mw, sz, m2r, rw, dst};
  endfunction

  function automatic logic ref_stall();
    logic [4:0] d;
    d = m_ex[4:0];
    return InstrValid && m_ex[10] && (d != 5'd0) &&
           ((d == Instruction[25:21]) || (ref_uses_rt(Instruction) && d == Instruction[20:16]));
  endfunction

  task automatic model_clear();
    m_ex = '0; m_mem = '0; m_wb = '0; m_sc = 0; m_fc = 0; m_ill = 1'b0;
  endtask

  // Update the model for the current inputs, then move to just after the next edge.
  task automatic advance();
    logic s;
    logic [CW-1:0] nx;
    s  = ref_stall();
    nx = (Flush || s || !InstrValid) ? '0 : ref_decode(Instruction);
    if (InstrValid && ref_illegal(Instruction)) m_ill = 1'b1;
    if (Flush) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
    else if (s) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
    m_wb = m_mem; m_mem = m_ex; m_ex = nx;
    @(posedge Clk); #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic f);
    Instruction = ins; InstrValid = v; Flush = f;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    drive(32'd0, 1'b0, 1'b0);
    model_clear();
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Rst = 1'b0;
    drive(32'd0, 1'b0, 1'b0);
    model_clear();
    #3;
    n_cmp++;
    if ({ExCtrl, MemCtrl, WbCtrl} !== '0) begin
      n_fail++; $display("FAIL reset_bundles: got %h/%h/%h want 0", ExCtrl, MemCtrl, WbCtrl);
    end
    n_cmp++;
    if ({IllegalOp, StallCount, FlushCount, Stall, PCWrite, IfIdWrite} !== {1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL reset_flags: ill=%b sc=%0d fc=%0d st=%b pcw=%b ifw=%b want 0 0 0 0 1 1",
                         IllegalOp, StallCount, FlushCount, Stall, PCWrite, IfIdWrite);
    end
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
  endtask

  task automatic test_addi_latency();
    logic [CW-1:0] want;
    want = {1'b0, 6'b001000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd5};
    drive(mk_i(6'b001000, 5'd2, 5'd5, 16'h0010), 1'b1, 1'b0);
    advance();
    drive(32'd0, 1'b0, 1'b0);
    n_cmp++;
    if (ExCtrl !== want) begin n_fail++; $display("FAIL addi_ex: got %h want %h", ExCtrl, want); end
    advance();
    n_cmp++;
    if (MemCtrl !== want || ExCtrl !== '0) begin
      n_fail++; $display("FAIL addi_mem: mem=%h ex=%h want %h/0", MemCtrl, ExCtrl, want);
    end
    advance();
    n_cmp++;
    if (WbCtrl !== want) begin n_fail++; $display("FAIL addi_wb: got %h want %h", WbCtrl, want); end
  endtask

  task automatic test_load_use();
    logic [CW-1:0] want_add;
    want_add = {1'b0, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 5'd9};
    do_reset();
    drive(mk_i(6'b100011, 5'd1, 5'd8, 16'h0004), 1'b1, 1'b0);
    advance();
    drive(mk_r(5'd8, 5'd3, 5'd9), 1'b1, 1'b0);
    @(negedge Clk);
    n_cmp++;
    if ({Stall, PCWrite, IfIdWrite} !== 3'b100) begin
      n_fail++; $display("FAIL load_use_stall: st/pcw/ifw=%b want 100", {Stall, PCWrite, IfIdWrite});
    end
    advance();
    n_cmp++;
    if (ExCtrl !== '0 || StallCount !== 4'd1) begin
      n_fail++; $display("FAIL load_use_bubble: ex=%h sc=%0d want 0/1", ExCtrl, StallCount);
    end
    @(negedge Clk);
    n_cmp++;
    if ({Stall, PCWrite} !== 2'b01) begin
      n_fail++; $display("FAIL load_use_release: st/pcw=%b want 01", {Stall, PCWrite});
    end
    advance();
    n_cmp++;
    if (ExCtrl !== want_add) begin n_fail++; $display("FAIL load_use_add: got %h want %h", ExCtrl, want_add); end
  endtask

  task automatic test_lw_zero();
    do_reset();
    drive(mk_i(6'b100011, 5'd1, 5'd0, 16'h0000), 1'b1, 1'b0);
    advance();
    drive(mk_r(5'd0, 5'd0, 5'd4), 1'b1, 1'b0);
    @(negedge Clk);
    n_cmp++;
    if (Stall !== 1'b0) begin n_fail++; $display("FAIL lw_zero_stall: got %b want 0", Stall); end
    advance();
    n_cmp++;
    if (ExCtrl !== ref_decode(mk_r(5'd0, 5'd0, 5'd4)) || StallCount !== 4'd0) begin
      n_fail++; $display("FAIL lw_zero_pass: ex=%h sc=%0d", ExCtrl, StallCount);
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    drive(mk_i(6'b100001, 5'd1, 5'd8, 16'h0002), 1'b1, 1'b0);
    advance();
    drive(mk_i(6'b101011, 5'd4, 5'd8, 16'h0000), 1'b1, 1'b1);
    @(negedge Clk);
    n_cmp++;
    if ({Stall, PCWrite, IfIdWrite, IfIdFlush} !== 4'b1111) begin
      n_fail++; $display("FAIL stall_flush_comb: st/pcw/ifw/iff=%b want 1111",
                         {Stall, PCWrite, IfIdWrite, IfIdFlush});
    end
    advance();
    n_cmp++;
    if (ExCtrl !== '0 || FlushCount !== 4'd1 || StallCount !== 4'd0) begin
      n_fail++; $display("FAIL stall_flush_regs: ex=%h fc=%0d sc=%0d want 0/1/0", ExCtrl, FlushCount, StallCount);
    end
  endtask

  task automatic test_jal_sb();
    logic [CW-1:0] want_jal, want_sb;
    want_jal = {1'b1, 6'b000011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd31};
    want_sb  = {1'b0, 6'b101000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 5'd0};
    drive({6'b000011, 26'h0123456}, 1'b1, 1'b0);
    advance();
    n_cmp++;
    if (ExCtrl !== want_jal) begin n_fail++; $display("FAIL jal: got %h want %h", ExCtrl, want_jal); end
    drive(mk_i(6'b101000, 5'd2, 5'd7, 16'h0003), 1'b1, 1'b0);
    advance();
    n_cmp++;
    if (ExCtrl !== want_sb) begin n_fail++; $display("FAIL sb: got %h want %h", ExCtrl, want_sb); end
  endtask

  task automatic test_illegal();
    do_reset();
    n_cmp++;
    if (IllegalOp !== 1'b0) begin n_fail++; $display("FAIL illegal_init: got %b want 0", IllegalOp); end
    drive(mk_i(6'b111111, 5'd3, 5'd4, 16'hffff), 1'b1, 1'b0);
    advance();
    n_cmp++;
    if (ExCtrl !== '0 || IllegalOp !== 1'b1) begin
      n_fail++; $display("FAIL illegal_set: ex=%h ill=%b want 0/1", ExCtrl, IllegalOp);
    end
    for (int i = 0; i < 3; i++) begin
      drive(mk_i(6'b001101, 5'd1, 5'd6, 16'h00ff), 1'b1, 1'b0);
      advance();
    end
    n_cmp++;
    if (IllegalOp !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky: got %b want 1", IllegalOp); end
    do_reset();
    n_cmp++;
    if (IllegalOp !== 1'b0) begin n_fail++; $display("FAIL illegal_clear: got %b want 0", IllegalOp); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < CMAX + 3; i++) begin
      drive(mk_i(6'b100000, 5'd1, 5'd8, 16'h0001), 1'b1, 1'b0);
      advance();
      drive(mk_r(5'd2, 5'd8, 5'd9), 1'b1, 1'b0);
      advance();
      advance();
    end
    n_cmp++;
    if (StallCount !== 4'(CMAX) || int'(StallCount) != m_sc) begin
      n_fail++; $display("FAIL stall_saturate: got %0d want %0d", StallCount, CMAX);
    end
    for (int i = 0; i < CMAX + 2; i++) begin
      drive(32'd0, 1'b0, 1'b1);
      advance();
    end
    n_cmp++;
    if (FlushCount !== 4'(CMAX) || StallCount !== 4'(CMAX)) begin
      n_fail++; $display("FAIL flush_saturate: fc=%0d sc=%0d want %0d/%0d", FlushCount, StallCount, CMAX, CMAX);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ins;
    do_reset();
    drive(32'd0, 1'b0, 1'b1);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(mk_i(6'b001000, 5'd1, 5'(i + 10), 16'h0001), 1'b1, 1'b0);
      advance();
    end
    #2 Rst = 1'b0;
    #1;
    model_clear();
    n_cmp++;
    if ({ExCtrl, MemCtrl, WbCtrl} !== '0 || FlushCount !== 4'd0) begin
      n_fail++; $display("FAIL reset_mid: ex=%h mem=%h wb=%h fc=%0d want all 0", ExCtrl, MemCtrl, WbCtrl, FlushCount);
    end
    @(posedge Clk); #1 Rst = 1'b1;
    ins = mk_i(6'b001110, 5'd1, 5'd12, 16'h0f0f);
    drive(ins, 1'b1, 1'b0);
    advance();
    n_cmp++;
    if (ExCtrl !== ref_decode(ins)) begin
      n_fail++; $display("FAIL reset_mid_resume: got %h want %h", ExCtrl, ref_decode(ins));
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [0:19];
    logic [5:0] op;
    logic       s;
    ops = '{6'o00, 6'o01, 6'o02, 6'o03, 6'o04, 6'o05, 6'o06, 6'o07, 6'o10, 6'o14,
            6'o15, 6'o16, 6'o40, 6'o41, 6'o43, 6'o43, 6'o50, 6'o51, 6'o53, 6'o77};
    do_reset();
    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 19)];
      drive({op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 11'($urandom)},
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0));
      @(negedge Clk);
      s = ref_stall();
      n_cmp++;
      if ({Stall, PCWrite, IfIdWrite, IfIdFlush} !== {s, !s || Flush, !s || Flush, Flush}) begin
        n_fail++; $display("FAIL rand_comb[%0d]: st/pcw/ifw/iff=%b want %b", i,
                           {Stall, PCWrite, IfIdWrite, IfIdFlush}, {s, !s || Flush, !s || Flush, Flush});
      end
      advance();
      n_cmp++;
      if ({ExCtrl, MemCtrl, WbCtrl} !== {m_ex, m_mem, m_wb} || IllegalOp !== m_ill ||
          int'(StallCount) != m_sc || int'(FlushCount) != m_fc) begin
        n_fail++; $display("FAIL rand_regs[%0d]: ex=%h mem=%h wb=%h ill=%b sc=%0d fc=%0d want %h %h %h %b %0d %0d",
                           i, ExCtrl, MemCtrl, WbCtrl, IllegalOp, StallCount, FlushCount,
                           m_ex, m_mem, m_wb, m_ill, m_sc, m_fc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi_latency();
    test_load_use();
    test_lw_zero();
    test_stall_flush();
    test_jal_sb();
    test_illegal();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Pipelined successor to the single-register MIPS controller. Decodes the instruction in the ID stage into a packed control bundle and carries it through the ID/EX, EX/MEM and MEM/WB stage registers. Detects load-use hazards and inserts bubbles; squashes on taken branch/jump. Provides link-register write for `jal`, byte/half/word memory-size control, illegal-opcode flagging and saturating stall/flush counters.

## Interface
- `OP_W`, 6: opcode width (Instruction[31:26]).
- `REG_W`, 5: register-address width.
- `LINK_REG`, 31: destination register for `jal`.
- `CNT_W`, 16: width of the performance counters.
- `Clk`  in  1  single clock, rising edge.
- `Rst`  in  1  reset, asynchronous, active-low.
- `Instruction`  in  32  IF/ID instruction (ID stage).
- `InstrValid`  in  1  IF/ID holds a real instruction.
- `Flush`  in  1  branch/jump taken, resolved in EX.
- `ExCtrl`, `MemCtrl`, `WbCtrl`  out  CTRL_W  registered bundles for the EX, MEM and WB stages.
- `Stall`  out  1  load-use hazard this cycle (combinational).
- `PCWrite`  out  1  `~Stall | Flush`.
- `IfIdWrite`  out  1  `~Stall | Flush`.
- `IfIdFlush`  out  1  equals `Flush`.
- `IllegalOp`  out  1  sticky: unknown opcode decoded while valid.
- `StallCount`, `FlushCount`  out  CNT_W  saturating event counters.

## Operation
- CTRL_W = 21. Bundle fields:
  - [20] Link
  - [19:14] ALUOp (= opcode)
  - [13] ALUSrc
  - [12] Branch
  - [11] Jump
  - [10] MemRead
  - [9] MemWrite
  - [8:7] MemSize (0 word, 1 half, 2 byte)
  - [6] MemtoReg (1 = ALU result, 0 = memory)
  - [5] RegWrite
  - [4:0] DestReg
- Decode per opcode:
  - R-type 000000: Dest = rd, RegWrite 1, MemtoReg 1.
  - addi/andi/ori/xori: Dest = rt, ALUSrc 1, RegWrite 1, MemtoReg 1.
  - lw/lh/lb (100011/100001/100000): ALUSrc 1, MemRead 1, RegWrite 1, Dest = rt, MemSize 0/1/2.
  - sw/sh/sb (101011/101001/101000): ALUSrc 1, MemWrite 1, MemSize 0/1/2.
  - beq/bne/blez/bgtz/regimm (000100/000101/000110/000111/000001): Branch 1.
  - j 000010: Jump 1.
  - jal 000011: Jump 1, Link 1, RegWrite 1, Dest = LINK_REG.
  - Any other opcode: all-zero bundle, and set IllegalOp.
- RegWrite is forced to 0 when DestReg = 0.
- Instructions that use rt as a source: R-type, stores, beq, bne.
- Stall = InstrValid & ExCtrl.MemRead & ExCtrl.DestReg≠0 & (DestReg==rs | (uses_rt & DestReg==rt)).
- ID/EX next value:
  - `Flush` high: zero (Flush has priority over Stall).
  - otherwise `Stall` high or `~InstrValid`: zero.
  - otherwise: the decoded bundle.
- EX/MEM and MEM/WB always advance: MemCtrl ← ExCtrl, WbCtrl ← MemCtrl.
- StallCount increments on each cycle with Stall & ~Flush. FlushCount increments on each cycle with Flush. Both saturate at all-ones and never wrap.

## Timing
- Reset (Rst = 0), asynchronous: ExCtrl, MemCtrl and WbCtrl are 0; IllegalOp 0; both counters 0. Stall follows the zeroed ExCtrl, so Stall = 0, PCWrite = 1, IfIdWrite = 1.
- Latency: instruction in ID at cycle n → ExCtrl at n+1, MemCtrl at n+2, WbCtrl at n+3.
- A load-use hazard yields exactly one Stall cycle. On the next cycle the load has moved to MEM, so Stall drops and the dependent instruction decodes normally.
- Flush with Stall in the same cycle: a bubble is inserted, PCWrite = 1, and only FlushCount increments.
- Reset asserted mid-pipeline discards every in-flight bundle. After deassertion the first valid decode appears at ExCtrl one cycle later.

## Structure
- Package `ctrl_pkg`: opcode constants, MemSize encodings, field bit offsets, CTRL_W.
- Sub-module `control_decoder`: purely combinational, Instruction → bundle plus illegal flag.
- Top level holds the stage registers, hazard logic and counters.

## Test plan
- After reset, `addi` with rt = 5 → ExCtrl = {Link 0, ALUOp 001000, ALUSrc 1, MemtoReg 1, RegWrite 1, Dest 5} one cycle later. MemCtrl then WbCtrl carry the same bundle on the following cycles.
- `lw $8`, then `add $9,$8,$3` → Stall = 1 for exactly one cycle with PCWrite = 0, bubble in ExCtrl, and StallCount = 1. The add reaches ExCtrl one cycle later.
- `lw $0` followed by a user of $0 → no stall.
- Stall and Flush asserted in the same cycle → ExCtrl = 0, PCWrite = 1, FlushCount +1, StallCount unchanged.
- `jal` → Dest = 31, Link = 1, RegWrite = 1, Jump = 1. `sb` → MemSize = 2, MemWrite = 1, RegWrite = 0.
- Opcode 111111 → zero bundle and IllegalOp held at 1 until reset.
- Force StallCount to all-ones → stays saturated.
- Reset pulsed mid-stream → all bundles 0 immediately.
